// File: rtl/pipe_adder_pkg.sv
// Shared types and flag helpers for the segmented pipelined add/subtract unit.
package pipe_adder_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    // Per-stage side record travelling alongside the partial sum.
    typedef struct packed {
        logic valid;
        op_e  op;
        logic sign_a;
        logic sign_b;
    } stage_rec_t;

    localparam stage_rec_t REC_IDLE = '{valid: 1'b0, op: OP_ADD, sign_a: 1'b0, sign_b: 1'b0};

    function automatic logic unsigned_ovf(input logic carry, input op_e op);
        return carry ^ logic'(op);
    endfunction

    function automatic logic signed_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/adder_seg_sv.sv
// One carry-chain segment: SW-bit add with carry-in, result and carry-out registered.
module adder_seg_sv #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    logic [SW:0]   w_sum;
    logic [SW-1:0] r_sum;
    logic          r_cout;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

    // Segment result register, held while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= {SW{1'b0}};
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_sum  <= w_sum[SW-1:0];
            r_cout <= w_sum[SW];
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: rtl/pipe_adder_sv.sv
// Pipelined add/subtract with valid/ready stream handshake; the carry chain is split
// into STAGES registered segments, with flags and saturation applied after the last one.
module pipe_adder_sv
    import pipe_adder_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter bit SIGNED = 1'b0,
    parameter bit SAT    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_0,
    input  logic [W-1:0] x_1,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf
);

    localparam int SW = W / STAGES;

    if ((STAGES < 1) || ((W % STAGES) != 0)) begin : g_bad_cfg
        $fatal(1, "pipe_adder_sv: W must be a multiple of STAGES and STAGES >= 1");
    end

    op_e        w_op;
    logic [W-1:0] w_b_eff;
    stage_rec_t w_rec0;
    logic       w_adv;

    assign w_op    = op_e'(op);
    assign w_b_eff = (w_op == OP_SUB) ? ~x_1 : x_1;
    assign w_rec0  = '{valid: in_valid, op: w_op, sign_a: x_0[W-1], sign_b: w_b_eff[W-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HW = (STAGES - k) * SW;

        logic [HW-1:0]         w_a_hi;
        logic [HW-1:0]         w_b_hi;
        logic                  w_cin;
        stage_rec_t            w_rec_in;
        logic [SW-1:0]         w_seg_sum;
        logic                  w_seg_cout;
        logic [(k+1)*SW-1:0]   w_low_out;
        stage_rec_t            r_rec;

        // Finished low segments are skewed forward so the full sum lines up at the end.
        if (k == 0) begin : g_head
            assign w_a_hi    = x_0;
            assign w_b_hi    = w_b_eff;
            assign w_cin     = op;
            assign w_rec_in  = w_rec0;
            assign w_low_out = w_seg_sum;
        end else begin : g_body
            logic [k*SW-1:0] r_low;

            assign w_a_hi    = g_stage[k-1].g_fwd.r_a_hi;
            assign w_b_hi    = g_stage[k-1].g_fwd.r_b_hi;
            assign w_cin     = g_stage[k-1].w_seg_cout;
            assign w_rec_in  = g_stage[k-1].r_rec;
            assign w_low_out = {w_seg_sum, r_low};

            // Skew register for the already-summed lower segments.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_low <= {(k*SW){1'b0}};
                end else if (w_adv) begin
                    r_low <= g_stage[k-1].w_low_out;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [HW-SW-1:0] r_a_hi;
            logic [HW-SW-1:0] r_b_hi;

            // Carry the not-yet-added upper operand segments to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_hi <= {(HW-SW){1'b0}};
                    r_b_hi <= {(HW-SW){1'b0}};
                end else if (w_adv) begin
                    r_a_hi <= w_a_hi[HW-1:SW];
                    r_b_hi <= w_b_hi[HW-1:SW];
                end
            end
        end

        adder_seg_sv #(.SW(SW)) u_seg (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_adv),
            .i_a    (w_a_hi[SW-1:0]),
            .i_b    (w_b_hi[SW-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_seg_sum),
            .o_cout (w_seg_cout)
        );

        // Stage valid/op/sign record; reset discards everything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rec <= REC_IDLE;
            end else if (w_adv) begin
                r_rec <= w_rec_in;
            end
        end
    end

    stage_rec_t   w_last;
    logic [W-1:0] w_raw;
    logic         w_carry;
    logic         w_ovf;
    logic [W-1:0] w_result;

    assign w_last  = g_stage[STAGES-1].r_rec;
    assign w_raw   = g_stage[STAGES-1].w_low_out;
    assign w_carry = g_stage[STAGES-1].w_seg_cout;
    assign w_adv   = !w_last.valid || out_ready;

    // Flags always describe the unsaturated operation; saturation only rewrites the result.
    always_comb begin
        w_result = w_raw;
        if (SIGNED) begin
            w_ovf = signed_ovf(w_last.sign_a, w_last.sign_b, w_raw[W-1]);
        end else begin
            w_ovf = unsigned_ovf(w_carry, w_last.op);
        end
        if (SAT && w_ovf) begin
            if (SIGNED) begin
                w_result = w_last.sign_a ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                w_result = (w_last.op == OP_SUB) ? {W{1'b0}} : {W{1'b1}};
            end
        end else begin
            w_result = w_raw;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = w_last.valid;
    assign result    = w_result;
    assign carry     = w_carry;
    assign ovf       = w_ovf;

endmodule
